// File: rtl/fpdiv_pkg.sv
// Shared constants for the sequential single-precision divider.
// FPDIV_RADIX4_EN selects two quotient bits per cycle (13 cycles instead of 26).
package fpdiv_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;

`ifdef FPDIV_RADIX4_EN
  localparam int STEPS = 13;
`else
  localparam int STEPS = 26;
`endif

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(STEPS);

  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [30:0] FP_INF_MAG = 31'h7F80_0000;

  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, FP_INF_MAG};
  endfunction

endpackage

// File: rtl/fp_divider_if.sv
// CPU-side run/stall handshake and operand/result bus of the divider.
interface fp_divider_if;
  logic        run;
  logic [31:0] x;
  logic [31:0] y;
  logic        stall;
  logic [31:0] z;

  modport master (output run, output x, output y, input stall, input z);
  modport slave  (input run, input x, input y, output stall, output z);
endinterface

// File: rtl/fpdiv_step.sv
// One restoring shift-subtract step: trial subtract, keep or restore, shift left.
module fpdiv_step (
  input  logic [24:0] rem_in,
  input  logic [23:0] divisor,
  output logic [24:0] rem_out,
  output logic        q_bit
);
  logic [25:0] diff;
  logic [24:0] kept;
  logic        unused_kept_msb;

  always_comb begin
    diff  = {1'b0, rem_in} - {2'b00, divisor};
    q_bit = ~diff[25];
    kept  = q_bit ? diff[24:0] : rem_in;
    // The remainder stays below twice the divisor, so the dropped MSB is always 0.
    rem_out = {kept[23:0], 1'b0};
  end

  assign unused_kept_msb = kept[24];
endmodule

// File: rtl/fp_divider.sv
// Sequential FP divider z = x / y, restoring, stalls the CPU until the quotient is ready.
// Define FPDIV_RADIX4_EN to chain two steps per cycle.
module fp_divider
  import fpdiv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fp_divider_if.slave  bus
);
  logic [CNT_W-1:0] s_q, s_d;
  logic [24:0]      r_q, r_d;
  logic [25:0]      q_q, q_d;

  logic        sign;
  logic [7:0]  xe, ye;
  logic [23:0] xm, ym;
  logic [24:0] rin;
  logic [24:0] rem1;
  logic        qb1;

  assign sign = bus.x[31] ^ bus.y[31];
  assign xe   = bus.x[30:23];
  assign ye   = bus.y[30:23];
  assign xm   = {1'b1, bus.x[22:0]};
  assign ym   = {1'b1, bus.y[22:0]};
  assign rin  = (s_q == '0) ? {1'b0, xm} : r_q;

  fpdiv_step u_step0 (.rem_in(rin), .divisor(ym), .rem_out(rem1), .q_bit(qb1));

`ifdef FPDIV_RADIX4_EN
  logic [24:0] rem2;
  logic        qb2;
  fpdiv_step u_step1 (.rem_in(rem1), .divisor(ym), .rem_out(rem2), .q_bit(qb2));
`endif

  always_comb begin
    s_d = s_q;
    r_d = r_q;
    q_d = q_q;
    if (!bus.run) begin
      s_d = '0;
    end else if (s_q != TERM_CNT) begin
      s_d = s_q + 1'b1;
`ifdef FPDIV_RADIX4_EN
      r_d = rem2;
      q_d = {q_q[23:0], qb1, qb2};
`else
      r_d = rem1;
      q_d = {q_q[24:0], qb1};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= '0;
      r_q <= '0;
      q_q <= '0;
    end else begin
      s_q <= s_d;
      r_q <= r_d;
      q_q <= q_d;
    end
  end

  // Normalise to 24 significant bits and round half-up on the next bit down.
  logic [25:0] rnd;
  logic        carry;
  logic [22:0] mant;
  logic [9:0]  e1;
  logic        e_under, e_over;
  logic [31:0] res;
  logic        unused_rnd;

  always_comb begin
    rnd   = q_q[25] ? ({1'b0, q_q[25:1]} + 26'd1) : ({1'b0, q_q[24:0]} + 26'd1);
    carry = rnd[25];
    mant  = rnd[23:1];
    e1    = {2'b00, xe} - {2'b00, ye} + 10'(BIAS) - {9'b0, ~q_q[25]} + {9'b0, carry};
    e_under = e1[9] || (e1 == 10'd0);
    e_over  = !e1[9] && (e1 >= 10'd255);
    res = {sign, e1[7:0], mant};
    if (ye == 8'd0)       res = fp_inf(sign);
    else if (xe == 8'd0)  res = FP_ZERO;
    else if (e_under)     res = FP_ZERO;
    else if (e_over)      res = fp_inf(sign);
  end

  assign unused_rnd = rnd[24] ^ rnd[0];

  assign bus.stall = bus.run & (s_q != TERM_CNT);
  assign bus.z     = (s_q == TERM_CNT) ? res : FP_ZERO;
endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed table, abort/reset sequences, random vs model.
module tb_fp_divider;

`ifdef FPDIV_RADIX4_EN
  localparam int EXP_STALL = 13;
`else
  localparam int EXP_STALL = 26;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_divider_if bus();
  fp_divider dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: exact integer quotient floor(xm*2^25/ym), then normalise and round.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint unsigned q, m;
    int              e;
    logic            s;
    logic [31:0]     inf;
    s   = a[31] ^ b[31];
    inf = {s, 8'hFF, 23'h0};
    if (b[30:23] == 8'd0) return inf;
    if (a[30:23] == 8'd0) return 32'h0;
    q = (longint'({1'b1, a[22:0]}) << 25) / longint'({1'b1, b[22:0]});
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= (64'd1 << 25)) begin
      m = (q + 2) >> 2;
    end else begin
      m = (q + 1) >> 1;
      e = e - 1;
    end
    if (m >= (64'd1 << 24)) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e <= 0) return 32'h0;
    if (e >= 255) return inf;
    return {s, e[7:0], m[22:0]};
  endfunction

  // Called #1 after a rising edge; runs one FDV and checks latency and result.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_z);
    int cnt;
    logic [31:0] zres;
    bus.x   = a;
    bus.y   = b;
    bus.run = 1'b1;
    #1;
    cnt = 0;
    while (bus.stall === 1'b1 && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    zres = bus.z;
    check({name, " stall_cycles"}, 32'(cnt), 32'(EXP_STALL));
    check({name, " z"}, zres, exp_z);
    $display("op %s x=%08h y=%08h z=%08h exp=%08h stall=%0d", name, a, b, zres, exp_z, cnt);
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    check({name, " z_idle"}, bus.z, 32'h0);
  endtask

  vec_t tbl[14];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int pulse_at;

    tbl[0]  = '{"6/2",        32'h40C00000, 32'h40000000, 32'h40400000};
    tbl[1]  = '{"1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAB};
    tbl[2]  = '{"-8/0.5",     32'hC1000000, 32'h3F000000, 32'hC1800000};
    tbl[3]  = '{"0/2",        32'h00000000, 32'h40000000, 32'h00000000};
    tbl[4]  = '{"1/0",        32'h3F800000, 32'h00000000, 32'h7F800000};
    tbl[5]  = '{"-1/0",       32'hBF800000, 32'h00000000, 32'hFF800000};
    tbl[6]  = '{"0/0",        32'h00000000, 32'h00000000, 32'h7F800000};
    tbl[7]  = '{"underflow",  32'h00800000, 32'h7F000000, 32'h00000000};
    tbl[8]  = '{"overflow",   32'h7F000000, 32'h00800000, 32'h7F800000};
    tbl[9]  = '{"e1_zero",    32'h3F800000, 32'h7EC00000, 32'h00000000};
    tbl[10] = '{"e1_one",     32'h3F800000, 32'h7E400000, 32'h00AAAAAB};
    tbl[11] = '{"e1_254",     32'h7F000000, 32'h3F800000, 32'h7F000000};
    tbl[12] = '{"e1_255",     32'h7F000000, 32'h3F000000, 32'h7F800000};
    tbl[13] = '{"1/0.99..",   32'h3F800000, 32'h3F7FFFFF, 32'h3F800001};

    rst     = 1'b1;
    bus.run = 1'b0;
    bus.x   = 32'h0;
    bus.y   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", {31'b0, bus.stall}, 32'h0);
    check("reset z", bus.z, 32'h0);
    bus.run = 1'b1;
    #1;
    check("reset run stall", {31'b0, bus.stall}, 32'h1);
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++)
      do_op(tbl[i].name, tbl[i].x, tbl[i].y, tbl[i].z);

    // Abort mid-way, then a fresh operation must take the full latency.
    bus.x = 32'h40C00000;
    bus.y = 32'h40000000;
    bus.run = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort midway stall", {31'b0, bus.stall}, 32'h1);
    bus.run = 1'b0;
    @(posedge clk);
    #1;
    check("abort dropped stall", {31'b0, bus.stall}, 32'h0);
    @(posedge clk);
    #1;
    do_op("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000);

    // Reset pulse while running restarts the count from zero.
    pulse_at = (EXP_STALL > 15) ? 15 : 10;
    bus.run = 1'b1;
    repeat (pulse_at) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst pulse stall", {31'b0, bus.stall}, 32'h1);
    check("rst pulse z", bus.z, 32'h0);
    #2;
    rst = 1'b0;
    do_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 2 == 1) begin
        a[30:23] = 8'($urandom_range(100, 160));
        b[30:23] = 8'($urandom_range(100, 160));
      end
      do_op($sformatf("rand%0d", i), a, b, ref_div(a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
